// File: rtl/uart_rx_buffered_if.sv
// Valid/ready byte stream carrying received UART bytes from the receiver to its consumer.
`timescale 1ns/1ps
interface uart_rx_buffered_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection, framing-error detection
// and a show-ahead byte FIFO drained over a valid/ready interface.
`timescale 1ns/1ps
module uart_rx_buffered #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_uart_rx,
  uart_rx_buffered_if.master            rx_bus,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [1:0]       r_rst_sync;
  logic             w_rst;
  logic [1:0]       r_sync;
  logic             w_rx_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic             w_push, w_ferr;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_frame_err, r_overflow;
  logic             w_valid, w_pop, w_full, w_do_push;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  // Two-flop synchroniser on the asynchronous serial line; idles high.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_uart_rx};
  end
  assign w_rx_s = r_sync[1];

  // Receiver state register.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Receiver next-state: half-bit wait from start edge puts every later sample at a bit centre.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
        else         w_state_nxt = S_IDLE;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          w_idx_nxt = 3'd0;
          if (w_rx_s) w_state_nxt = S_IDLE;
          else        w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_BREAK;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && rx_bus.ready;
  assign w_full    = (r_count == DEPTH_C);
  assign w_do_push = w_push && (!w_full || w_pop);

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  assign rx_bus.valid = w_valid;
  assign rx_bus.data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed scoreboard bench for uart_rx_buffered at 16 clocks per bit and a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_buffered;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int BIT_NS = CPB * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_count;

  uart_rx_buffered_if bus ();

  uart_rx_buffered #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_uart_rx    (uart_rx),
    .rx_bus       (bus),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte is compared against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.data);
      end else begin
        chk("rx_byte", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bit_ns);
    @(posedge clk);
    #1 uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #(bit_ns) uart_rx = b[i];
    end
    #(bit_ns) uart_rx = stop_v;
    #(bit_ns);
    uart_rx = 1'b1;
  endtask

  task automatic wait_empty(input int max_cyc);
    int n = 0;
    while (fifo_count != 3'd0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_to_empty", {29'h0, fifo_count}, 32'd0);
  endtask

  initial begin
    bus.ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_valid", {31'h0, bus.valid}, 32'd0);
    chk("rst_data", {24'h0, bus.data}, 32'h00);
    chk("rst_count", {29'h0, fifo_count}, 32'd0);
    chk("rst_ferr", {31'h0, frame_err}, 32'd0);
    chk("rst_ovf", {31'h0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Test 1: single byte, push visible one cycle after the stop sample, popped immediately.
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, BIT_NS);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        chk("t1_not_yet_valid", {31'h0, bus.valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_valid", {31'h0, bus.valid}, 32'd1);
        chk("t1_data", {24'h0, bus.data}, 32'h55);
        chk("t1_count1", {29'h0, fifo_count}, 32'd1);
        @(negedge clk);
        chk("t1_valid_fall", {31'h0, bus.valid}, 32'd0);
        chk("t1_count0", {29'h0, fifo_count}, 32'd0);
      end
    join
    repeat (10) @(negedge clk);

    // Test 3: 6-cycle start glitch is ignored and the receiver is ready for a real frame.
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t3_count", {29'h0, fifo_count}, 32'd0);
    chk("t3_ferr", ferr_cnt, 32'd0);
    exp_q.push_back(8'hC5);
    send_frame(8'hC5, 1'b1, BIT_NS);
    repeat (10) @(negedge clk);

    // Test 4: bad stop bit then held-low line gives one frame error, then clean recovery.
    send_frame(8'hA3, 1'b0, BIT_NS);
    uart_rx = 1'b0;
    repeat (100) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_ferr_once", ferr_cnt, 32'd1);
    chk("t4_no_push", {29'h0, fifo_count}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    repeat (10) @(negedge clk);
    chk("t4_drained", {29'h0, fifo_count}, 32'd0);

    // Test 5: full FIFO, push coincides with pop.
    bus.ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1, BIT_NS);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1, BIT_NS);
    exp_q.push_back(8'h33); send_frame(8'h33, 1'b1, BIT_NS);
    exp_q.push_back(8'h44); send_frame(8'h44, 1'b1, BIT_NS);
    repeat (5) @(negedge clk);
    chk("t5_full", {29'h0, fifo_count}, 32'd4);
    exp_q.push_back(8'h99);
    fork
      send_frame(8'h99, 1'b1, BIT_NS);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 bus.ready = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
        @(negedge clk);
        chk("t5_count_stays", {29'h0, fifo_count}, 32'd4);
        chk("t5_no_ovf", {31'h0, overflow}, 32'd0);
        chk("t5_head", {24'h0, bus.data}, 32'h22);
      end
    join
    bus.ready = 1'b1;
    wait_empty(20);
    repeat (5) @(negedge clk);

    // Test 2: six frames into a 4-deep FIFO with no consumer.
    bus.ready = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, BIT_NS);
    end
    repeat (5) @(negedge clk);
    chk("t2_count", {29'h0, fifo_count}, 32'd4);
    chk("t2_head", {24'h0, bus.data}, 32'h01);
    chk("t2_ovf", {31'h0, overflow}, 32'd1);
    bus.ready = 1'b1;
    wait_empty(20);
    chk("t2_valid_fall", {31'h0, bus.valid}, 32'd0);

    // Test 6: reset mid-frame with two bytes queued, then clean reception and baud offsets.
    bus.ready = 1'b0;
    exp_q.push_back(8'h5A); send_frame(8'h5A, 1'b1, BIT_NS);
    exp_q.push_back(8'hC3); send_frame(8'hC3, 1'b1, BIT_NS);
    repeat (5) @(negedge clk);
    chk("t6_queued", {29'h0, fifo_count}, 32'd2);
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (16) @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", {31'h0, bus.valid}, 32'd0);
    chk("t6_rst_data", {24'h0, bus.data}, 32'h00);
    chk("t6_rst_count", {29'h0, fifo_count}, 32'd0);
    chk("t6_rst_ovf", {31'h0, overflow}, 32'd0);
    chk("t6_rst_ferr", {31'h0, frame_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    bus.ready = 1'b1;
    exp_q.push_back(8'h7E); send_frame(8'h7E, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, 155);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1, 165);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, 165);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1, 155);
    repeat (20) @(negedge clk);

    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_ferr_total", ferr_cnt, 32'd1);
    chk("final_count", {29'h0, fifo_count}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
